key_event_arbiter: RTL and testbench

//  Front end between the raw push-buttons (E/F/G) and the datapath that drives A-D and the 7-seg display.

---
 rtl/key_event_arbiter.sv | 135 +++++++++++++
 tb/tb_key_event_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// Key front end: synchronise and debounce each raw key, turn presses into events,
// and deliver one pending event at a time through a round-robin arbiter and valid/ready.
module key_event_arbiter #(
   parameter  int N_KEYS          = 3,
   parameter  int SYNC_STAGES     = 2,
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int ID_W            = $clog2(N_KEYS)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [N_KEYS-1:0] key_in,
   input  logic              evt_ready,
   output logic              evt_valid,
   output logic [ID_W-1:0]   evt_id,
   output logic [N_KEYS-1:0] key_level,
   output logic              overrun
);

   localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_KEYS - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

   logic [N_KEYS-1:0] sync_q [SYNC_STAGES];
   logic [N_KEYS-1:0] key_s;
   logic [CNT_W-1:0]  cnt_q  [N_KEYS];
   logic [CNT_W-1:0]  cnt_d  [N_KEYS];
   logic [N_KEYS-1:0] level_q, level_d;
   logic [N_KEYS-1:0] level_dly_q;
   logic [N_KEYS-1:0] press;
   logic [N_KEYS-1:0] pending_q, pending_d;
   logic [N_KEYS-1:0] clr;
   logic              overrun_q, overrun_d;
   state_e            state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   last_q, last_d;

   // First requester strictly after last, wrapping modulo N_KEYS.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_KEYS-1:0] req,
                                               input logic [ID_W-1:0]   last);
      logic [ID_W-1:0] pick;
      int              idx;
      pick = last;
      for (int i = N_KEYS; i >= 1; i--) begin
         idx = (int'(last) + i) % N_KEYS;
         if (req[idx[ID_W-1:0]]) pick = idx[ID_W-1:0];
      end
      return pick;
   endfunction

   assign key_s = sync_q[SYNC_STAGES-1];

   // NOTE: sync_q and cnt_q are plain flop arrays, so they are reset like any other register.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= key_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      level_d = level_q;
      for (int k = 0; k < N_KEYS; k++) begin
         cnt_d[k] = '0;
         if (key_s[k] != level_q[k]) begin
            if (cnt_q[k] == CNT_LAST) level_d[k] = key_s[k];
            else                      cnt_d[k]   = cnt_q[k] + CNT_W'(1);
         end
      end
   end

   assign press = level_q & ~level_dly_q;

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      last_d  = last_q;
      clr     = '0;
      case (state_q)
         IDLE: begin
            if (|pending_q) begin
               id_d    = rr_pick(pending_q, last_q);
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               clr     = N_KEYS'(1) << id_q;
               last_d  = id_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A press landing on the clearing cycle is kept as a fresh pending event.
      pending_d = (pending_q & ~clr) | press;
      overrun_d = |(press & pending_q & ~clr);
   end

   // NOTE: all state below updates with <= so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int k = 0; k < N_KEYS; k++) cnt_q[k] <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         pending_q   <= '0;
         overrun_q   <= 1'b0;
         state_q     <= IDLE;
         id_q        <= '0;
         last_q      <= LAST_INIT;
      end else begin
         for (int k = 0; k < N_KEYS; k++) cnt_q[k] <= cnt_d[k];
         level_q     <= level_d;
         level_dly_q <= level_q;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         state_q     <= state_d;
         id_q        <= id_d;
         last_q      <= last_d;
      end
   end

   assign evt_valid = (state_q == OFFER);
   assign evt_id    = id_q;
   assign key_level = level_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus random key activity, checked
// per cycle against a transaction-level reference model and an event scoreboard.
module tb_key_event_arbiter;

   localparam int N    = 3;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int IDW  = 2;

   logic           sys_clk = 1'b0;
   logic           sys_rst;
   logic [N-1:0]   key_in;
   logic           evt_ready;
   logic           evt_valid;
   logic [IDW-1:0] evt_id;
   logic [N-1:0]   key_level;
   logic           overrun;

   key_event_arbiter #(
      .N_KEYS         (N),
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_in   (key_in),
      .evt_ready(evt_ready),
      .evt_valid(evt_valid),
      .evt_id   (evt_id),
      .key_level(key_level),
      .overrun  (overrun)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state, expressed as sample histories, a pending set and an offer slot.
   logic [N-1:0] m_sync [SYNC];
   logic [N-1:0] m_hist [DEB];
   logic [N-1:0] m_level, m_level_prev, m_pending;
   logic         m_overrun;
   int           m_offer, m_id, m_last;
   int           exp_q[$];
   int           got_ids[$];
   int           ev_cnt[4];
   int           ovr_cnt = 0;

   function automatic int pick_next(input logic [N-1:0] req, input int last);
      int idx;
      for (int i = 1; i <= N; i++) begin
         idx = (last + i) % N;
         if (req[idx[IDW-1:0]]) return idx;
      end
      return -1;
   endfunction

   always @(posedge sys_clk or posedge sys_rst) begin : model
      logic [N-1:0] s, press, clr, new_level;
      logic         hs, all_diff;
      if (sys_rst) begin
         for (int j = 0; j < SYNC; j++) m_sync[j] = '0;
         for (int j = 0; j < DEB; j++)  m_hist[j] = '0;
         m_level = '0; m_level_prev = '0; m_pending = '0; m_overrun = 1'b0;
         m_offer = -1; m_id = 0; m_last = N - 1;
         exp_q.delete();
      end else begin
         s     = m_sync[SYNC-1];
         press = m_level & ~m_level_prev;
         hs    = (m_offer >= 0) && evt_ready;
         clr   = hs ? (N'(1) << m_offer) : '0;
         m_overrun = |(press & m_pending & ~clr);
         if (hs) begin
            m_last  = m_offer;
            m_offer = -1;
         end else if (m_offer < 0 && m_pending != '0) begin
            m_offer = pick_next(m_pending, m_last);
            m_id    = m_offer;
            exp_q.push_back(m_offer);
         end
         m_pending = (m_pending & ~clr) | press;
         // A key changes level once its last DEB synchronised samples all disagree with it.
         for (int j = DEB - 1; j >= 1; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = s;
         new_level = m_level;
         for (int k = 0; k < N; k++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (m_hist[j][k] == m_level[k]) all_diff = 1'b0;
            if (all_diff) new_level[k] = ~m_level[k];
         end
         m_level_prev = m_level;
         m_level      = new_level;
         for (int j = SYNC - 1; j >= 1; j--) m_sync[j] = m_sync[j-1];
         m_sync[0] = key_in;
      end
   end

   always @(negedge sys_clk) begin : monitor
      if (!sys_rst) begin
         check("evt_valid", 32'(evt_valid), 32'(m_offer >= 0));
         check("evt_id",    32'(evt_id),    32'(m_id));
         check("key_level", 32'(key_level), 32'(m_level));
         check("overrun",   32'(overrun),   32'(m_overrun));
         if (overrun === 1'b1) ovr_cnt++;
         if (evt_valid && evt_ready) begin
            check("sb_expected_event", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) check("sb_evt_id", 32'(evt_id), 32'(exp_q.pop_front()));
            got_ids.push_back(int'(evt_id));
            ev_cnt[evt_id]++;
         end
      end
   end

   task automatic step(input logic [N-1:0] k, input logic r, input int n);
      key_in    = k;
      evt_ready = r;
      repeat (n) @(posedge sys_clk);
      #2;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int base0, base1, base2, ov0, sz;
      sys_rst   = 1'b1;
      key_in    = '0;
      evt_ready = 1'b0;
      for (int i = 0; i < 4; i++) ev_cnt[i] = 0;
      repeat (2) @(posedge sys_clk);
      #1;
      check("rst_evt_valid", 32'(evt_valid), 32'(0));
      check("rst_evt_id",    32'(evt_id),    32'(0));
      check("rst_key_level", 32'(key_level), 32'(0));
      check("rst_overrun",   32'(overrun),   32'(0));
      #1;
      sys_rst = 1'b0;

      // Clean press: exact latency of level and offer.
      key_in    = 3'b001;
      evt_ready = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(posedge sys_clk);
         #1;
         if (e == 5 || e == 6) check("t1_level_edge", 32'(key_level[0]), 32'(e == 6));
         check("t1_valid_edge", 32'(evt_valid), 32'(e == 8));
         if (e == 8) check("t1_evt_id", 32'(evt_id), 32'(0));
         #1;
      end
      step(3'b000, 1'b1, 12);
      check("t1_one_event", 32'(ev_cnt[0]), 32'(1));

      // Bounce on key1 is filtered, then a steady press yields one event.
      for (int i = 0; i < 5; i++) begin
         step(3'b010, 1'b1, 1);
         step(3'b000, 1'b1, 2);
      end
      step(3'b000, 1'b1, 4);
      check("t2_bounce_level", 32'(key_level), 32'(0));
      check("t2_bounce_events", 32'(ev_cnt[1]), 32'(0));
      check("t2_bounce_overrun", 32'(ovr_cnt), 32'(0));
      step(3'b010, 1'b1, 10);
      step(3'b000, 1'b1, 12);
      check("t2_one_event", 32'(ev_cnt[1]), 32'(1));

      // Round-robin after key0 was last served.
      step(3'b001, 1'b1, 10);
      step(3'b000, 1'b1, 12);
      step(3'b101, 1'b1, 12);
      step(3'b000, 1'b1, 12);
      sz = got_ids.size();
      check("t3_order_first",  32'(got_ids[sz-2]), 32'(2));
      check("t3_order_second", 32'(got_ids[sz-1]), 32'(0));

      // Backpressure with a merged second press of key2.
      base2 = ev_cnt[2];
      ov0   = ovr_cnt;
      step(3'b100, 1'b0, 10);
      step(3'b000, 1'b0, 8);
      step(3'b100, 1'b0, 10);
      check("t4_held_valid", 32'(evt_valid), 32'(1));
      check("t4_held_id",    32'(evt_id),    32'(2));
      check("t4_one_overrun", 32'(ovr_cnt),  32'(ov0 + 1));
      step(3'b100, 1'b1, 1);
      step(3'b000, 1'b1, 12);
      check("t4_single_event", 32'(ev_cnt[2]), 32'(base2 + 1));
      check("t4_drained", 32'(evt_valid), 32'(0));

      // Press edge of key1 coincides with its own handshake.
      base1 = ev_cnt[1];
      ov0   = ovr_cnt;
      step(3'b010, 1'b0, 10);
      step(3'b000, 1'b0, 10);
      step(3'b010, 1'b0, 6);
      step(3'b010, 1'b1, 1);
      step(3'b010, 1'b0, 4);
      check("t5_reoffer_valid", 32'(evt_valid), 32'(1));
      check("t5_reoffer_id",    32'(evt_id),    32'(1));
      check("t5_first_taken",   32'(ev_cnt[1]), 32'(base1 + 1));
      check("t5_no_overrun",    32'(ovr_cnt),   32'(ov0));
      step(3'b000, 1'b1, 12);
      check("t5_two_events", 32'(ev_cnt[1]), 32'(base1 + 2));

      // Async reset while an event is offered.
      step(3'b100, 1'b0, 10);
      base2 = ev_cnt[2];
      sys_rst = 1'b1;
      #1;
      check("t6_rst_valid",   32'(evt_valid), 32'(0));
      check("t6_rst_level",   32'(key_level), 32'(0));
      check("t6_rst_overrun", 32'(overrun),   32'(0));
      repeat (2) @(posedge sys_clk);
      #2;
      sys_rst = 1'b0;
      step(3'b100, 1'b1, 5);
      check("t6_no_early_event", 32'(evt_valid), 32'(0));
      step(3'b100, 1'b1, 10);
      step(3'b000, 1'b1, 12);
      check("t6_fresh_event", 32'(ev_cnt[2]), 32'(base2 + 1));

      // Random key activity and backpressure.
      repeat (150) begin
         step(3'($urandom), 1'($urandom_range(0, 9) < 7), int'($urandom_range(1, 12)));
      end
      step(3'b000, 1'b1, 30);
      check("sb_all_delivered", 32'(exp_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
